// File: rtl/pipe_reg_array.sv
// Elastic register pipeline: WIDTH-bit payload through DEPTH stages with
// valid/ready flow control, bubble collapsing, synchronous flush and a
// registered occupancy count. Stage 0 faces the input, DEPTH-1 the output.

// One pipeline stage: valid bit plus payload register.
module pipe_reg_stage #(
  parameter int WIDTH      = 36,
  parameter bit RESET_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             flush,
  input  logic             load,
  input  logic             adv,
  input  logic [WIDTH-1:0] din,
  output logic             vld,
  output logic [WIDTH-1:0] dat
);

  // Payload only moves when a load happens outside a flush; a flush keeps data.
  logic ld_dat;
  assign ld_dat = load & ~flush;

  // Valid: set on load, cleared when the word leaves without a replacement.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)      vld <= 1'b0;
    else if (flush) vld <= 1'b0;
    else if (load)  vld <= 1'b1;
    else if (adv)   vld <= 1'b0;
  end

  generate
    if (RESET_DATA) begin : g_rst
      // Payload register with asynchronous clear.
      always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)       dat <= '0;
        else if (ld_dat) dat <= din;
      end
    end else begin : g_nrst
      // Payload register without reset.
      always_ff @(posedge clk) begin
        if (ld_dat) dat <= din;
      end
    end
  endgenerate

endmodule

module pipe_reg_array #(
  parameter int WIDTH      = 36,
  parameter int DEPTH      = 2,
  parameter bit RESET_DATA = 1'b1
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]            vld;
  logic [DEPTH-1:0]            adv;
  logic [DEPTH-1:0]            load;
  logic [DEPTH-1:0][WIDTH-1:0] dat;
  logic [DEPTH-1:0][WIDTH-1:0] din;
  logic                        full_above;
  logic                        acc;
  logic                        emit;

  // Advance terms. A stage advances when it holds a word and either some stage
  // downstream of it is empty or every downstream stage is full and the output
  // drains; this is the unrolled ready chain, so no combinational self-loop.
  always_comb begin
    full_above = 1'b1;
    adv        = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      adv[k]     = vld[k] & (~full_above | out_ready);
      full_above = full_above & vld[k];
    end
  end

  // in_ready never looks at in_valid; it follows the ready chain from out_ready.
  assign in_ready  = ~flush & (~vld[0] | adv[0]);
  assign acc       = in_valid & in_ready;
  assign emit      = adv[DEPTH-1];
  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_head
        assign load[k] = acc;
        assign din[k]  = in_data;
      end else begin : g_body
        assign load[k] = adv[k-1];
        assign din[k]  = dat[k-1];
      end

      pipe_reg_stage #(
        .WIDTH      (WIDTH),
        .RESET_DATA (RESET_DATA)
      ) u_stage (
        .clk   (clk),
        .rstN  (rstN),
        .flush (flush),
        .load  (load[k]),
        .adv   (adv[k]),
        .din   (din[k]),
        .vld   (vld[k]),
        .dat   (dat[k])
      );
    end
  endgenerate

  // Occupancy tracks accepts minus output transfers; flush empties the pipe.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)              occupancy <= '0;
    else if (flush)         occupancy <= '0;
    else if (acc && !emit)  occupancy <= occupancy + OCC_W'(1);
    else if (!acc && emit)  occupancy <= occupancy - OCC_W'(1);
  end

endmodule

// File: tb/tb_pipe_reg_array.sv
// Bench for pipe_reg_array: three instances (DEPTH 2, 3, 4) share one input
// stream; a word-position queue model predicts each one every cycle, and the
// directed scenarios pin literal values on the instance they focus on.
module tb_pipe_reg_array;

  localparam int W = 36;
  localparam int DEP [3] = '{2, 3, 4};

  logic         clk = 1'b0;
  logic         rstN = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [2:0]   iry;
  logic [2:0]   ov;
  logic [W-1:0] od0, od1, od2;
  logic [1:0]   occ0, occ1;
  logic [2:0]   occ2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_reg_array #(.WIDTH(W), .DEPTH(2), .RESET_DATA(1'b1)) u_d2 (
    .clk(clk), .rstN(rstN), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(iry[0]), .out_valid(ov[0]), .out_data(od0), .out_ready(out_ready),
    .occupancy(occ0));
  pipe_reg_array #(.WIDTH(W), .DEPTH(3), .RESET_DATA(1'b1)) u_d3 (
    .clk(clk), .rstN(rstN), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(iry[1]), .out_valid(ov[1]), .out_data(od1), .out_ready(out_ready),
    .occupancy(occ1));
  pipe_reg_array #(.WIDTH(W), .DEPTH(4), .RESET_DATA(1'b1)) u_d4 (
    .clk(clk), .rstN(rstN), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(iry[2]), .out_valid(ov[2]), .out_data(od2), .out_ready(out_ready),
    .occupancy(occ2));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // Model: per instance, a queue of words in acceptance order, each tagged with
  // the stage index it currently sits in (0 = input side).
  logic [W-1:0] mq   [3][8];
  int           mpos [3][8];
  int           mn   [3] = '{0, 0, 0};

  function automatic logic [W-1:0] get_od(input int d);
    return (d == 0) ? od0 : (d == 1) ? od1 : od2;
  endfunction

  function automatic int get_occ(input int d);
    return (d == 0) ? int'(occ0) : (d == 1) ? int'(occ1) : int'(occ2);
  endfunction

  function automatic bit exp_ov(input int d);
    return (mn[d] > 0) && (mpos[d][0] == DEP[d] - 1);
  endfunction

  // Every word steps one stage forward unless the word ahead (after its own
  // move) blocks it; the pipe can take a word if stage 0 ends up free.
  function automatic bit exp_ready(input int d);
    int prev;
    int s;
    s    = (exp_ov(d) && out_ready) ? 1 : 0;
    prev = DEP[d];
    for (int i = s; i < mn[d]; i++) begin
      prev = (mpos[d][i] + 1 < prev - 1) ? mpos[d][i] + 1 : prev - 1;
    end
    return !flush && (prev >= 1);
  endfunction

  // Model update on each edge (and immediately on reset).
  always @(posedge clk or negedge rstN) begin
    bit a;
    bit e;
    int prev;
    if (!rstN) begin
      for (int d = 0; d < 3; d++) mn[d] = 0;
    end else begin
      for (int d = 0; d < 3; d++) begin
        a = in_valid && exp_ready(d);
        e = exp_ov(d) && out_ready;
        if (e) begin
          for (int i = 0; i < 7; i++) begin
            mq[d][i]   = mq[d][i+1];
            mpos[d][i] = mpos[d][i+1];
          end
          mn[d]--;
        end
        prev = DEP[d];
        for (int i = 0; i < mn[d]; i++) begin
          mpos[d][i] = (mpos[d][i] + 1 < prev - 1) ? mpos[d][i] + 1 : prev - 1;
          prev = mpos[d][i];
        end
        if (flush) mn[d] = 0;
        else if (a) begin
          mq[d][mn[d]]   = in_data;
          mpos[d][mn[d]] = 0;
          mn[d]++;
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d.in_ready", DEP[d]), 64'(iry[d]), 64'(exp_ready(d)));
      chk($sformatf("d%0d.out_valid", DEP[d]), 64'(ov[d]), 64'(exp_ov(d)));
      if (exp_ov(d))
        chk($sformatf("d%0d.out_data", DEP[d]), 64'(get_od(d)), 64'(mq[d][0]));
      chk($sformatf("d%0d.occupancy", DEP[d]), 64'(get_occ(d)), 64'(mn[d]));
    end
  end

  task automatic nxt;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_all;
    flush = 1'b1;
    in_valid = 1'b0;
    nxt;
    flush = 1'b0;
  endtask

  logic [W-1:0] got [32];
  int ngot, w, nacc, errs, first_acc, first_ov, occ_mid, seen;
  logic [W-1:0] firstout;

  initial begin
    // Reset state, checked while rstN is still low.
    #1;
    chk("reset.in_ready", 64'(iry), 64'h7);
    chk("reset.out_valid", 64'(ov), 64'h0);
    chk("reset.occupancy_d3", 64'(occ1), 64'h0);
    chk("reset.occupancy_d4", 64'(occ2), 64'h0);
    chk("reset.out_data_d3", 64'(od1), 64'h0);
    #2;
    rstN = 1'b1;
    nxt;

    // Streaming through DEPTH=3 at full rate.
    out_ready = 1'b1;
    w = 1; ngot = 0; first_acc = -1; first_ov = -1; occ_mid = -1;
    for (int c = 0; c < 40; c++) begin
      in_valid = (w <= 16);
      in_data  = W'(w);
      #1;
      if (ov[1]) begin
        if (first_ov < 0) first_ov = c;
        if (ngot < 32) got[ngot] = od1;
        ngot++;
      end
      if (in_valid && iry[1]) begin
        if (first_acc < 0) first_acc = c;
        w++;
      end
      if (c == 8) occ_mid = int'(occ1);
      nxt;
      if (ngot >= 16) break;
    end
    // accepted on the edge closing cycle first_acc, visible after the edge
    // closing cycle first_ov-1: two edges later for DEPTH=3
    chk("stream.latency_edges", 64'(first_ov - first_acc - 1), 64'd2);
    chk("stream.count", 64'(ngot), 64'd16);
    errs = 0;
    for (int i = 0; i < 16 && i < ngot; i++) if (got[i] !== W'(i + 1)) errs++;
    chk("stream.order_errs", 64'(errs), 64'd0);
    chk("stream.first", 64'(got[0]), 64'h1);
    chk("stream.last", 64'(got[15]), 64'h10);
    // every word spends three edge intervals inside at full rate
    chk("stream.occ_mid", 64'(occ_mid), 64'd3);
    in_valid = 1'b0;
    clear_all;

    // Stall fill on DEPTH=3: five offered, three taken.
    out_ready = 1'b0;
    w = 1; nacc = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (w <= 5);
      in_data  = W'(w);
      #1;
      if (in_valid && iry[1]) begin nacc++; w++; end
      nxt;
    end
    chk("stall.accepted", 64'(nacc), 64'd3);
    in_valid = 1'b1;
    #1;
    chk("stall.in_ready", 64'(iry[1]), 64'h0);
    chk("stall.occupancy", 64'(occ1), 64'd3);
    out_ready = 1'b1;
    ngot = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = (w <= 5);
      in_data  = W'(w);
      #1;
      if (ov[1]) begin
        if (ngot < 32) got[ngot] = od1;
        ngot++;
      end
      if (in_valid && iry[1]) w++;
      nxt;
      if (ngot >= 5) break;
    end
    chk("stall.count", 64'(ngot), 64'd5);
    errs = 0;
    for (int i = 0; i < 5 && i < ngot; i++) if (got[i] !== W'(i + 1)) errs++;
    chk("stall.order_errs", 64'(errs), 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    clear_all;

    // Bubble collapse on DEPTH=4: a lone word slides to the last stage.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 36'h0ABC;
    #1;
    chk("bubble.accept", 64'(iry[2]), 64'h1);
    nxt;
    in_valid = 1'b0;
    repeat (3) nxt;
    #1;
    chk("bubble.out_valid", 64'(ov[2]), 64'h1);
    chk("bubble.out_data", 64'(od2), 64'h0ABC);
    chk("bubble.occupancy", 64'(occ2), 64'd1);
    chk("bubble.in_ready", 64'(iry[2]), 64'h1);
    repeat (2) nxt;
    #1;
    chk("bubble.stable", 64'(od2), 64'h0ABC);
    clear_all;

    // Full DEPTH=2 with a simultaneous accept and emit.
    out_ready = 1'b0;
    in_valid = 1'b1;
    w = 'h21;
    for (int c = 0; c < 4; c++) begin
      in_data = W'(w);
      #1;
      if (iry[0]) w++;
      nxt;
    end
    in_valid = 1'b0;
    #1;
    chk("full.occupancy", 64'(occ0), 64'd2);
    chk("full.in_ready_stalled", 64'(iry[0]), 64'h0);
    in_valid = 1'b1;
    in_data = 36'h23;
    out_ready = 1'b1;
    #1;
    chk("full.in_ready_draining", 64'(iry[0]), 64'h1);
    chk("full.out_data", 64'(od0), 64'h21);
    nxt;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("full.occ_after", 64'(occ0), 64'd2);
    chk("full.next_word", 64'(od0), 64'h22);
    clear_all;

    // Flush with DEPTH=3 full and in_valid high.
    out_ready = 1'b0;
    in_valid = 1'b1;
    w = 'h31;
    for (int c = 0; c < 5; c++) begin
      in_data = W'(w);
      #1;
      if (iry[1]) w++;
      nxt;
    end
    flush = 1'b1;
    in_data = 36'h99;
    #1;
    chk("flush.in_ready", 64'(iry[1]), 64'h0);
    nxt;
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush.out_valid", 64'(ov[1]), 64'h0);
    chk("flush.occupancy", 64'(occ1), 64'd0);
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      #1;
      if (ov[1]) seen++;
      nxt;
    end
    chk("flush.no_ghost", 64'(seen), 64'd0);

    // Asynchronous reset mid-stream, then a clean restart.
    in_valid = 1'b1;
    w = 'h41;
    for (int c = 0; c < 5; c++) begin
      in_data = W'(w);
      #1;
      if (iry[1]) w++;
      nxt;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    rstN = 1'b0;
    #1;
    chk("areset.out_valid", 64'(ov[1]), 64'h0);
    chk("areset.occupancy", 64'(occ1), 64'd0);
    chk("areset.out_data", 64'(od1), 64'h0);
    chk("areset.in_ready", 64'(iry[1]), 64'h1);
    nxt;
    rstN = 1'b1;
    out_ready = 1'b1;
    w = 'h51;
    firstout = '0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid = (w <= 'h53);
      in_data  = W'(w);
      #1;
      if (ov[1] && seen == 0) begin firstout = od1; seen = 1; end
      if (in_valid && iry[1]) w++;
      nxt;
    end
    chk("areset.restart_first", 64'(firstout), 64'h51);
    in_valid = 1'b0;
    out_ready = 1'b0;
    nxt;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
